// File: rtl/twiddle_gen.sv
// Twiddle-factor generator for a 1024-point FFT: derives cos/sin of 2*pi*k/1024
// from a quarter-wave cosine ROM (257 points folded into 256 addresses) with two reads.
module twiddle_gen #(
  parameter int KW = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KW-1:0]       req_k,
  output logic                twact,
  output logic [7:0]          twa,
  input  logic [14:0]         twdr_cos,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic signed [15:0]  tw_cos,
  output logic signed [15:0]  tw_sin
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP,
    OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [KW-1:0]      r_k;
  logic [14:0]        r_a;

  logic [7:0]         w_m;
  logic               w_q;
  logic               w_mZero;
  logic signed [15:0] w_aExt;
  logic signed [15:0] w_bExt;
  logic signed [15:0] w_cos;
  logic signed [15:0] w_sin;

  assign w_m     = r_k[7:0];
  assign w_q     = r_k[KW-1];
  assign w_mZero = (w_m == 8'd0);
  assign w_aExt  = {1'b0, r_a};
  assign w_bExt  = {1'b0, twdr_cos};

  // Second quadrant is a 90-degree rotation of the first; m==0 would otherwise pick C[0].
  always_comb begin
    w_cos = w_aExt;
    w_sin = w_mZero ? 16'sd0 : w_bExt;
    if (w_q) begin
      w_cos = w_mZero ? 16'sd0 : -w_bExt;
      w_sin = w_aExt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    twact     = 1'b0;
    twa       = 8'd0;
    req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = RD_A;
        end
      end
      RD_A: begin
        twact  = 1'b1;
        twa    = w_m;
        w_next = RD_B;
      end
      RD_B: begin
        twact  = 1'b1;
        twa    = 8'd0 - w_m;
        w_next = CAP;
      end
      CAP: begin
        w_next = OUT;
      end
      OUT: begin
        if (tw_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ROM data lags the address by one cycle, so A lands while in RD_B and B while in CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k      <= '0;
      r_a      <= '0;
      tw_valid <= 1'b0;
      tw_cos   <= '0;
      tw_sin   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_k <= req_k;
          end
        end
        RD_B: begin
          r_a <= twdr_cos;
        end
        CAP: begin
          tw_cos   <= w_cos;
          tw_sin   <= w_sin;
          tw_valid <= 1'b1;
        end
        OUT: begin
          if (tw_ready) begin
            tw_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen: directed vector table, backpressure/reset
// sequences and random indices checked against a real-arithmetic twiddle model.
module tb_twiddle_gen;

  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [8:0]         req_k;
  logic               twact;
  logic [7:0]         twa;
  logic [14:0]        twdr_cos;
  logic               tw_valid;
  logic               tw_ready;
  logic signed [15:0] tw_cos;
  logic signed [15:0] tw_sin;

  logic [14:0] rom [256];

  int total;
  int bad;

  typedef struct {
    logic [8:0] k;
    int         lowCycles;
    int         expCos;
    int         expSin;
  } vec_t;

  vec_t vecs [6];

  twiddle_gen #(.KW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_k    (req_k),
    .twact    (twact),
    .twa      (twa),
    .twdr_cos (twdr_cos),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_cos   (tw_cos),
    .tw_sin   (tw_sin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the enabled address.
  always @(posedge clk) begin
    if (twact) begin
      twdr_cos <= rom[twa];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int roundReal(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference: exact trigonometry rounded to Q14, independent of the ROM folding.
  function automatic void modelTwiddle(input int k, output int c, output int s);
    real theta;
    theta = 2.0 * PI * real'(k) / 1024.0;
    c = roundReal(16384.0 * $cos(theta));
    s = roundReal(16384.0 * $sin(theta));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Caller sits at a negedge. Runs one transaction, holding tw_ready low for
  // lowCycles cycles in OUT; holdNext keeps a new request pending during that time.
  task automatic applyStimulus(input int k, input int lowCycles, input int expCos,
                               input int expSin, input bit holdNext, input int nextK);
    int m;
    m = k % 256;
    tw_ready  = 1'b0;
    req_valid = 1'b1;
    req_k     = 9'(k);
    checkOutput("req_ready idle", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_k     = 9'($urandom);
    checkOutput("twact rd_a", int'(twact), 1);
    checkOutput("twa rd_a", int'(twa), m);
    checkOutput("req_ready busy", int'(req_ready), 0);
    @(negedge clk);
    req_valid = 1'($urandom);
    checkOutput("twact rd_b", int'(twact), 1);
    checkOutput("twa rd_b", int'(twa), (256 - m) % 256);
    @(negedge clk);
    req_valid = 1'($urandom);
    checkOutput("twact cap", int'(twact), 0);
    checkOutput("twa cap", int'(twa), 0);
    checkOutput("tw_valid cap", int'(tw_valid), 0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("tw_valid out", int'(tw_valid), 1);
    checkOutput("tw_cos", int'(tw_cos), expCos);
    checkOutput("tw_sin", int'(tw_sin), expSin);
    checkOutput("twact out", int'(twact), 0);
    if (holdNext) begin
      req_valid = 1'b1;
      req_k     = 9'(nextK);
    end
    for (int i = 0; i < lowCycles; i++) begin
      @(negedge clk);
      checkOutput("tw_valid held", int'(tw_valid), 1);
      checkOutput("tw_cos held", int'(tw_cos), expCos);
      checkOutput("tw_sin held", int'(tw_sin), expSin);
      checkOutput("req_ready held", int'(req_ready), 0);
    end
    tw_ready = 1'b1;
    @(negedge clk);
    tw_ready = 1'b0;
    checkOutput("tw_valid cleared", int'(tw_valid), 0);
    checkOutput("req_ready after out", int'(req_ready), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tw_valid"}, int'(tw_valid), 0);
    checkOutput({tag, " tw_cos"}, int'(tw_cos), 0);
    checkOutput({tag, " tw_sin"}, int'(tw_sin), 0);
    checkOutput({tag, " twact"}, int'(twact), 0);
    checkOutput({tag, " twa"}, int'(twa), 0);
  endtask

  initial begin
    int c;
    int s;
    int k;

    total     = 0;
    bad       = 0;
    req_valid = 1'b0;
    req_k     = '0;
    tw_ready  = 1'b0;
    twdr_cos  = '0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 15'(roundReal(16384.0 * $cos(2.0 * PI * real'(i) / 1024.0)));
    end

    vecs[0] = '{k: 9'd0,   lowCycles: 0, expCos: 16384, expSin: 0};
    vecs[1] = '{k: 9'd128, lowCycles: 1, expCos: 11585, expSin: 11585};
    vecs[2] = '{k: 9'd1,   lowCycles: 0, expCos: 16384, expSin: 101};
    vecs[3] = '{k: 9'd256, lowCycles: 2, expCos: 0,     expSin: 16384};
    vecs[4] = '{k: 9'd300, lowCycles: 0, expCos: -4370, expSin: 15791};
    vecs[5] = '{k: 9'd511, lowCycles: 0, expCos: -16384, expSin: 101};

    rst = 1'b1;
    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("req_ready after reset", int'(req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'(vecs[i].k), vecs[i].lowCycles, vecs[i].expCos, vecs[i].expSin, 1'b0, 0);
    end

    // Backpressure with a competing request that must wait for IDLE.
    applyStimulus(64, 3, 15137, 6270, 1'b1, 5);
    modelTwiddle(5, c, s);
    applyStimulus(5, 0, c, s, 1'b0, 0);

    // Reset while in RD_B aborts the k=300 read.
    req_valid = 1'b1;
    req_k     = 9'd300;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rd_b before abort", int'(twa), 212);
    rst = 1'b1;
    #1;
    checkAllZero("abort rd_b");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no result after abort", int'(tw_valid), 0);
    end
    applyStimulus(0, 0, 16384, 0, 1'b0, 0);

    // Reset while presenting a result in OUT.
    req_valid = 1'b1;
    req_k     = 9'd64;
    repeat (4) @(negedge clk);
    req_valid = 1'b0;
    checkOutput("out before abort", int'(tw_cos), 15137);
    rst = 1'b1;
    #1;
    checkAllZero("abort out");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle after out abort", int'(req_ready), 1);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(511, 0));
      modelTwiddle(k, c, s);
      applyStimulus(k, int'($urandom_range(2, 0)), c, s, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter KW, default 9: twiddle index width for a 1024-point FFT (k = 0..511); only 9 is supported.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: twiddle request present.
REQ-005 SHALL have port req_ready, output, 1: block can accept a request.
REQ-006 SHALL have port req_k, input, KW: twiddle index k.
REQ-007 SHALL have port twact, output, 1: cosine-ROM read enable.
REQ-008 SHALL have port twa, output, 8: cosine-ROM address.
REQ-009 SHALL have port twdr_cos, input, 15: cosine-ROM data, unsigned Q14, valid 1 cycle after twact/twa.
REQ-010 SHALL have port tw_valid, output, 1: twiddle result valid.
REQ-011 SHALL have port tw_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port tw_cos, output, 16: signed Q14 cos(2*pi*k/1024).
REQ-013 SHALL have port tw_sin, output, 16: signed Q14 +sin(2*pi*k/1024).

Function
REQ-014 SHALL implement FSM states IDLE, RD_A, RD_B, CAP, OUT; req_ready = 1 iff state is IDLE.
REQ-015 IDLE: on edge with req_valid & req_ready, SHALL register k and go to RD_A; else stay.
REQ-016 RD_A: SHALL drive twact=1, twa=m (m = k[7:0]); next state RD_B.
REQ-017 RD_B: SHALL drive twact=1, twa=(256-m) mod 256; on the edge leaving RD_B SHALL capture twdr_cos as A=C[m]; next state CAP.
REQ-018 CAP: twact=0; on the edge leaving CAP SHALL capture twdr_cos as B=C[256-m], load tw_cos/tw_sin, set tw_valid=1, go to OUT.
REQ-019 Result mapping (q = k[8]): q=0 -> cos=A, sin=(m==0 ? 0 : B); q=1 -> cos=(m==0 ? 0 : -B), sin=A.
REQ-020 Arithmetic: ROM values zero-extended to 16 bits before negation; no saturation needed (max magnitude 16384).
REQ-021 Latency: tw_valid SHALL rise on the 3rd rising edge after the accepting edge.
REQ-022 OUT: tw_valid, tw_cos, tw_sin SHALL hold stable until an edge with tw_ready=1; that edge clears tw_valid and returns to IDLE.
REQ-023 req_valid SHALL be ignored in every state other than IDLE; no request buffering; throughput at most one per 5 cycles with tw_ready tied high.
REQ-024 In IDLE, CAP and OUT, twact SHALL be 0 and twa SHALL be 0.
REQ-025 req_k changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 While rst=1: state IDLE, tw_valid=0, tw_cos=0, tw_sin=0, twact=0, twa=0, internal k/A=0; req_ready=1 after rst deasserts.
REQ-027 rst asserted in any state, including mid-read or OUT, SHALL abort the operation immediately; no result emitted after release.

Verification
REQ-028 k=0, tw_ready=1 -> twa sequence 0,0; tw_cos=16384, tw_sin=0; tw_valid 3 edges after accept.
REQ-029 k=128 -> tw_cos=11585, tw_sin=11585; k=1 -> tw_cos=16384, tw_sin=101.
REQ-030 k=256 -> tw_cos=0, tw_sin=16384; k=300 (m=44) -> twa 44 then 212, tw_cos=-4370, tw_sin=15791.
REQ-031 Backpressure: k=64, tw_ready low 3 cycles, req_valid held high with k=5 -> outputs stay 15137/6270, req_ready=0; after tw_ready, k=5 is then accepted.
REQ-032 Reset in RD_B with k=300, then release -> all outputs 0, no tw_valid; next request k=0 completes correctly.
